// File: rtl/playback_timer.sv
// Purpose: BCD mm:ss track timer with prescaler, up/down count, preload, done flag and wrap pulse.
// Latency: digits, done, wrap and load_err are registered; a tick or load is visible 1 clk later.
// Backpressure: none; count=0 holds all state, and clear > load > tick resolves same-cycle requests.
// Optional build macro PLAYBACK_TIMER_7SEG_EN adds 7-segment outputs ({g,f,e,d,c,b,a}, active high).
module playback_timer #(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 1,
  parameter int STEP_W     = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    count,
  input  logic                    clear,
  input  logic                    dir,
  input  logic [STEP_W-1:0]       step,
  input  logic                    load,
  input  logic [4*MIN_DIGITS-1:0] load_min,
  input  logic [3:0]              load_sec1,
  input  logic [3:0]              load_sec0,
  output logic [3:0]              seconds0,
  output logic [3:0]              seconds1,
  output logic [4*MIN_DIGITS-1:0] minutes,
  output logic                    done,
  output logic                    wrap,
  output logic                    load_err
`ifdef PLAYBACK_TIMER_7SEG_EN
  ,
  output logic [6:0]              seg_s0,
  output logic [6:0]              seg_s1,
  output logic [7*MIN_DIGITS-1:0] seg_min
`endif
);

  localparam int LW   = 4 * MIN_DIGITS;
  // Largest displayable time in seconds, e.g. 99:59 -> 5999 for two minute digits.
  localparam int MAXT = (10 ** MIN_DIGITS) * 60 - 1;
  // Wide enough to hold MAXT plus the largest step before the wrap correction.
  localparam int TW   = $clog2(MAXT + (1 << STEP_W) + 1);
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre;
  logic          load_ok;
  logic          tick;
  logic [TW-1:0] t_cur;
  logic [TW-1:0] t_sum;
  logic [TW-1:0] t_next;
  logic          wrap_next;
  logic          done_next;

  // BCD digits -> total seconds (cheap multiply-accumulate by constants).
  function automatic logic [TW-1:0] to_bin(input logic [LW-1:0] m,
                                           input logic [3:0] s1,
                                           input logic [3:0] s0);
    logic [TW-1:0] acc;
    acc = '0;
    for (int i = MIN_DIGITS - 1; i >= 0; i--) begin
      acc = acc * TW'(10) + TW'(m[4*i +: 4]);
    end
    return acc * TW'(60) + TW'(s1) * TW'(10) + TW'(s0);
  endfunction

  // Total seconds -> {minutes, tens of seconds, units of seconds} in BCD.
  function automatic logic [LW+7:0] to_bcd(input logic [TW-1:0] t);
    logic [TW-1:0] m;
    logic [TW-1:0] r;
    logic [LW+7:0] d;
    m      = t / TW'(60);
    r      = t - m * TW'(60);
    d      = '0;
    d[3:0] = 4'(r % TW'(10));
    d[7:4] = 4'(r / TW'(10));
    for (int i = 0; i < MIN_DIGITS; i++) begin
      d[8 + 4*i +: 4] = 4'(m % TW'(10));
      m               = m / TW'(10);
    end
    return d;
  endfunction

  // Load is accepted only when every digit is a legal BCD value and tens of seconds <= 5.
  always_comb begin
    load_ok = (load_sec1 <= 4'd5) && (load_sec0 <= 4'd9);
    for (int i = 0; i < MIN_DIGITS; i++) begin
      if (load_min[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // A tick fires on the last prescaler phase of an enabled cycle that is not a clear/load.
  assign tick  = count && !clear && !load && (pre == PW'(TICK_DIV - 1));
  assign t_cur = to_bin(minutes, seconds1, seconds0);
  assign t_sum = t_cur + TW'(step);

  // Next time value on a tick: modular add going up, saturating subtract going down.
  always_comb begin
    t_next    = t_cur;
    wrap_next = 1'b0;
    done_next = done;
    if (!dir) begin
      if (t_sum > TW'(MAXT)) begin
        t_next    = t_sum - TW'(MAXT + 1);
        wrap_next = 1'b1;
      end else begin
        t_next = t_sum;
      end
    end else if (!done) begin
      // Once done, down ticks leave the value alone; otherwise clamp at zero.
      t_next = (t_cur > TW'(step)) ? (t_cur - TW'(step)) : '0;
      if (t_next == '0) done_next = 1'b1;
    end
  end

  // Timer state: clear beats load, load beats tick; pulses default low every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre      <= '0;
      minutes  <= '0;
      seconds1 <= '0;
      seconds0 <= '0;
      done     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (clear) begin
        pre      <= '0;
        minutes  <= '0;
        seconds1 <= '0;
        seconds0 <= '0;
        done     <= 1'b0;
      end else if (load) begin
        if (load_ok) begin
          pre      <= '0;
          minutes  <= load_min;
          seconds1 <= load_sec1;
          seconds0 <= load_sec0;
          done     <= 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (count) begin
        if (tick) begin
          pre                              <= '0;
          {minutes, seconds1, seconds0}    <= to_bcd(t_next);
          wrap                             <= wrap_next;
          done                             <= done_next;
        end else begin
          pre <= pre + PW'(1);
        end
      end
    end
  end

`ifdef PLAYBACK_TIMER_7SEG_EN
  // One BCD digit to segments {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Segment outputs follow the registered digits in the same cycle.
  always_comb begin
    seg_s0  = seg7(seconds0);
    seg_s1  = seg7(seconds1);
    seg_min = '0;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      seg_min[7*i +: 7] = seg7(minutes[4*i +: 4]);
    end
  end
`else
  // Segment decoding is done by external driver7seg instances in this build.
`endif

endmodule

// File: doc/playback_timer.md
Name: playback_timer

Overview:
Parametrised BCD mm:ss track timer for the music player. It succeeds the fixed 1-minute-digit timer and adds:
- configurable minute-digit count
- tick prescaler
- count-up and count-down modes
- track-length preload
- end-of-track flag and wrap pulse

Sits between the player control FSM and the 7-segment drivers.

Parameters:
- MIN_DIGITS, 2, number of BCD minute digits; maximum time is (10^MIN_DIGITS − 1):59.
- TICK_DIV, 1, clk cycles per timer tick (≥1).
- STEP_W, 6, width of the step input in seconds.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- count  in  1  1 = prescaler runs and ticks apply; 0 = hold everything.
- clear  in  1  synchronous clear of time, prescaler and done.
- dir  in  1  0 = count up, 1 = count down.
- step  in  STEP_W  seconds added or subtracted per tick, binary 0..2^STEP_W−1.
- load  in  1  synchronous preload strobe.
- load_min  in  4*MIN_DIGITS  BCD minutes to preload; least-significant digit in [3:0].
- load_sec1  in  4  BCD tens of seconds to preload (0–5).
- load_sec0  in  4  BCD units of seconds to preload (0–9).
- seconds0  out  4  BCD seconds units.
- seconds1  out  4  BCD seconds tens.
- minutes  out  4*MIN_DIGITS  BCD minutes.
- done  out  1  sticky: down-count has reached 00:00.
- wrap  out  1  one-cycle pulse on up-count overflow.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (reset=0, asynchronous): all digits 0, prescaler 0, done=0, wrap=0, load_err=0. Outputs go to zero immediately, with no clock edge needed.
- Priority at each clk edge: clear > load > tick.
- clear: digits 0, prescaler 0, done=0.
- load:
  - Accepted only if every load digit is ≤9 and load_sec1 ≤5.
  - On accept: digits ← load value, prescaler ← 0, done ← 0.
  - On reject: state unchanged, load_err=1 for one cycle.
- Prescaler:
  - Increments only while count=1 and no clear/load is active.
  - tick is asserted in the cycle where prescaler = TICK_DIV−1; the prescaler then wraps to 0.
  - TICK_DIV=1 gives a tick every enabled cycle.
- Tick, up (dir=0):
  - T ← T + step, where T = total seconds = minutes*60 + sec1*10 + sec0.
  - If T + step > MAX (MAX = (10^MIN_DIGITS)*60 − 1), the result is T + step − (MAX+1) and wrap=1 for that cycle.
- Tick, down (dir=1):
  - T ← T − step, saturating at 0.
  - When the result is 0, done is set.
  - Once done=1, further down ticks hold 00:00.
- step=0: a tick causes no change; done is still set if T=0 and dir=1.
- Digit outputs are registered. The new value is visible directly after the tick edge (latency 1 clk from the tick condition). Outputs are always valid BCD with seconds1 ≤5.
- dir may change at any cycle; it takes effect on the next tick. done persists across a dir change until clear, load or reset.
- count=0: prescaler and digits hold. wrap and load_err remain 0 unless caused by a load.
- The implementation may keep a binary seconds counter with BCD conversion, or use digit-wise BCD add/subtract. Either way, the registered outputs must be identical.

Optional Feature:
- PLAYBACK_TIMER_7SEG_EN defined: adds output ports seg_s0 (7), seg_s1 (7), seg_min (7*MIN_DIGITS).
  - Active-high segment order {g,f,e,d,c,b,a}.
  - Decoded combinationally from the registered digits (0 shows 7'b0111111).
  - Same-cycle validity as the digit outputs.
- Undefined: these ports and the decoders do not exist; external driver7seg instances are used instead.

Test Plan:
1. Reset and basic up-count (MIN_DIGITS=2, TICK_DIV=1): reset=0 mid-run → all outputs 0 at once, with no clk edge. Then reset=1, count=1, dir=0, step=1, 75 clks → 01:15, done=0.
2. Hold and prescaler: count=0 for 100 clks → value unchanged. With TICK_DIV=4, step=1, count=1, 40 clks from 00:00 → 00:10.
3. Multi-second step and wrap:
   - Load 00:50, step=15, one tick → 01:05.
   - Load 99:30, step=45, one tick → 00:15 with wrap=1 for exactly one cycle.
4. Count-down to end: load 03:20, dir=1, step=8, 25 ticks → 00:00, done=1. 3 further ticks → still 00:00, done=1. Then load 00:10 → done=0.
5. Invalid load and priority:
   - Load with load_sec1=6 → load_err pulse, time unchanged.
   - clear and load in the same cycle → 00:00.
   - load and tick in the same cycle → loaded value, no step applied.
6. With PLAYBACK_TIMER_7SEG_EN: at 01:15, seg_s0=7'b1101101, seg_s1=7'b0000110, seg_min[6:0]=7'b0000110.
